// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared state/grant types and widths for the cache port arbiter.
package cache_arbiter_pkg;
    typedef enum logic [1:0] {Idle, Access, Done} state_e;
    typedef enum logic {GrantI, GrantD} grant_e;
    localparam int TIMEOUT_COUNTER_BITWIDTH = 16;
endpackage

// File: rtl/cache_arbiter_arbiter_rr2.sv
// arbiter_rr2: two-way round-robin arbiter; CACHE_ARBITER_DATA_PRIORITY_EN selects fixed D-first priority.
module arbiter_rr2
    import cache_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_valid,
    output logic [1:0] grant
);
`ifdef CACHE_ARBITER_DATA_PRIORITY_EN
    always_comb grant = req[1] ? 2'b10 : {1'b0, req[0]};
`else
    grant_e last_grant;
    always_comb grant = (&req) ? ((last_grant == GrantD) ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk) begin
        if (!rst_n) last_grant <= GrantD;
        else if (grant_valid && |grant) last_grant <= grant[1] ? GrantD : GrantI;
    end
`endif
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cache port between instruction fetch and data access, with busy watchdog.
// Define CACHE_ARBITER_DATA_PRIORITY_EN for fixed data-first priority instead of round-robin.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int BusyTimeoutCycles = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_ack,
    output logic [31:0] i_data,
    input  logic        d_req,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_write_enable,
    input  logic [31:0] d_data_in,
    output logic        d_ack,
    output logic [31:0] d_data,
    output logic        cache_enable,
    output logic [31:0] cache_address,
    output logic [3:0]  cache_write_enable,
    output logic [31:0] cache_data_in,
    input  logic [31:0] cache_data_out,
    input  logic        cache_data_out_ready,
    input  logic        cache_busy,
    output logic        timeout
);
    localparam logic [TIMEOUT_COUNTER_BITWIDTH-1:0] Limit = TIMEOUT_COUNTER_BITWIDTH'(BusyTimeoutCycles);

    state_e state, state_n;
    grant_e grant_q;
    logic [1:0] grant;
    logic [31:0] addr_q, wdata_q, i_data_q, d_data_q;
    logic [3:0] we_q;
    logic [TIMEOUT_COUNTER_BITWIDTH-1:0] busy_cnt, busy_cnt_n;
    logic timeout_q, rd_done, wr_done;

    arbiter_rr2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         ({d_req, i_req}),
        .grant_valid (state == Idle),
        .grant       (grant)
    );

    always_comb begin
        rd_done    = state == Access && !cache_busy && we_q == 4'b0 && cache_data_out_ready;
        wr_done    = state == Access && !cache_busy && we_q != 4'b0;
        busy_cnt_n = (&busy_cnt) ? busy_cnt : busy_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= Idle;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            Idle:    state_n = (|grant) ? Access : Idle;
            Access:  state_n = (rd_done || wr_done) ? Done : Access;
            default: state_n = Idle;
        endcase
    end

    always_comb begin
        cache_enable       = state == Access;
        cache_address      = addr_q;
        cache_write_enable = we_q;
        cache_data_in      = wdata_q;
        i_ack              = state == Done && grant_q == GrantI;
        d_ack              = state == Done && grant_q == GrantD;
        i_data             = i_data_q;
        d_data             = d_data_q;
        timeout            = timeout_q;
    end

    // Request ports are only sampled in Idle; the cache sees registered values only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q   <= GrantI;
            addr_q    <= '0;
            we_q      <= '0;
            wdata_q   <= '0;
            i_data_q  <= '0;
            d_data_q  <= '0;
            busy_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == Idle && |grant) begin
                grant_q <= grant[1] ? GrantD : GrantI;
                addr_q  <= grant[1] ? d_address : i_address;
                we_q    <= grant[1] ? d_write_enable : 4'b0;
                wdata_q <= grant[1] ? d_data_in : 32'b0;
            end
            if (state == Access && cache_busy) begin
                busy_cnt <= busy_cnt_n;
                if (busy_cnt_n >= Limit) timeout_q <= 1'b1;
            end
            if (state == Done) busy_cnt <= '0;
            if (rd_done && grant_q == GrantI) i_data_q <= cache_data_out;
            if (rd_done && grant_q == GrantD) d_data_q <= cache_data_out;
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed self-checking bench for cache_arbiter (BusyTimeoutCycles = 8).
module tb_cache_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_address = '0, d_address = '0, d_data_in = '0, cache_data_out = '0;
    logic [3:0]  d_write_enable = '0;
    logic        cache_data_out_ready = 1'b1, cache_busy = 1'b0;
    logic        i_ack, d_ack, cache_enable, timeout;
    logic [31:0] i_data, d_data, cache_address, cache_data_in;
    logic [3:0]  cache_write_enable;
    int checks = 0, errors = 0;

    cache_arbiter #(.BusyTimeoutCycles(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_data(i_data),
        .d_req(d_req), .d_address(d_address), .d_write_enable(d_write_enable),
        .d_data_in(d_data_in), .d_ack(d_ack), .d_data(d_data),
        .cache_enable(cache_enable), .cache_address(cache_address),
        .cache_write_enable(cache_write_enable), .cache_data_in(cache_data_in),
        .cache_data_out(cache_data_out), .cache_data_out_ready(cache_data_out_ready),
        .cache_busy(cache_busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_order [4];
        do_reset();
        check("rst_enable", cache_enable, 0);
        check("rst_addr", cache_address, 0);
        check("rst_acks", {i_ack, d_ack}, 0);
        check("rst_timeout", timeout, 0);

        // Read hit
        i_address = 32'h100; i_req = 1'b1; cache_data_out = 32'hDEADBEEF;
        tick();
        check("hit_enable", cache_enable, 1);
        check("hit_addr", cache_address, 32'h100);
        check("hit_we", cache_write_enable, 0);
        check("hit_ack_early", i_ack, 0);
        tick();
        check("hit_i_ack", i_ack, 1);
        check("hit_i_data", i_data, 32'hDEADBEEF);
        check("hit_d_ack", d_ack, 0);
        check("hit_done_enable", cache_enable, 0);
        i_req = 1'b0;
        tick();
        check("hit_ack_clear", i_ack, 0);

        // Miss with 12 busy cycles
        d_address = 32'h2004; d_req = 1'b1; cache_busy = 1'b1; cache_data_out = 32'h12345678;
        tick();
        for (int j = 0; j < 12; j++) begin
            check($sformatf("miss_hold_%0d", j), {cache_enable, d_ack, i_ack, cache_address}, {3'b100, 32'h2004});
            d_address = 32'hFFFF_0000;
            tick();
        end
        cache_busy = 1'b0;
        check("miss_plus_one", {cache_enable, d_ack, cache_address}, {2'b10, 32'h2004});
        tick();
        check("miss_d_ack", {d_ack, i_ack}, 2'b10);
        check("miss_d_data", d_data, 32'h12345678);
        check("miss_i_data_kept", i_data, 32'hDEADBEEF);
        check("miss_timeout", timeout, 1);
        d_req = 1'b0;
        tick();
        check("miss_ack_once", d_ack, 0);

        // Write: completes without ready, d_data untouched
        d_address = 32'h40; d_write_enable = 4'b0011; d_data_in = 32'h0000ABCD; d_req = 1'b1;
        cache_data_out_ready = 1'b0; cache_data_out = 32'h55555555;
        tick();
        check("wr_we", cache_write_enable, 4'b0011);
        check("wr_din", cache_data_in, 32'h0000ABCD);
        check("wr_addr", cache_address, 32'h40);
        tick();
        check("wr_d_ack", {d_ack, i_ack}, 2'b10);
        check("wr_d_data_kept", d_data, 32'h12345678);
        d_req = 1'b0; d_write_enable = 4'b0; cache_data_out_ready = 1'b1;
        tick();

        // Reset mid-miss
        d_address = 32'h800; d_req = 1'b1; cache_busy = 1'b1;
        tick();
        tick();
        check("mid_in_access", cache_enable, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_outs", {cache_enable, i_ack, d_ack, timeout, cache_write_enable}, 0);
        check("mid_rst_addr", cache_address, 0);
        check("mid_rst_d_data", d_data, 0);
        check("mid_rst_i_data", i_data, 0);
        rst_n = 1'b1; d_req = 1'b0; cache_busy = 1'b0;
        tick();
        check("mid_no_ack", d_ack, 0);
        i_address = 32'h300; i_req = 1'b1; cache_data_out = 32'hCAFEF00D;
        tick();
        tick();
        check("mid_next_ack", {i_ack, d_ack}, 2'b10);
        check("mid_next_data", i_data, 32'hCAFEF00D);
        i_req = 1'b0;
        tick();

        // Arbitration with both requests held
        do_reset();
`ifdef CACHE_ARBITER_DATA_PRIORITY_EN
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            check($sformatf("arb_%0d", k), {i_ack, d_ack}, exp_order[k]);
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Watchdog
        do_reset();
        i_address = 32'h500; i_req = 1'b1; cache_busy = 1'b1;
        tick();
        for (int b = 1; b <= 20; b++) begin
            tick();
            check($sformatf("wd_busy_%0d", b), timeout, (b >= 8) ? 1 : 0);
        end
        cache_busy = 1'b0;
        tick();
        check("wd_ack", i_ack, 1);
        i_req = 1'b0;
        tick();
        tick();
        check("wd_sticky", timeout, 1);
        do_reset();
        check("wd_cleared", timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
